// File: rtl/t02_arb_pkg.sv
// Shared types for the t02 memory arbiter: FSM states, grant encoding and
// the length of the post-strobe settle window.
package t02_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Cycles with strobes low and busy_o ignored, covering the RAM's late busy rise.
    localparam int SETTLE_CYCLES = 1;
    localparam int SETTLE_CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

endpackage

// File: rtl/t02_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// Build option: T02_ARB_ROUND_ROBIN_EN alternates ties; otherwise data wins ties.
module t02_arb_pick
    import t02_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output grant_t winner
);

    always_comb begin
        // NOTE: default assigned first so every path drives winner and no latch is inferred.
        winner = last_grant;
        if (i_req && d_req) begin
`ifdef T02_ARB_ROUND_ROBIN_EN
            winner = (last_grant == GNT_D) ? GNT_I : GNT_D;
`else
            winner = GNT_D;
`endif
        end else if (d_req) begin
            winner = GNT_D;
        end else if (i_req) begin
            winner = GNT_I;
        end
    end

endmodule

// File: rtl/t02_mem_arbiter.sv
// Shares one RAM port between instruction fetch and load/store traffic.
// Tie policy selected by T02_ARB_ROUND_ROBIN_EN inside t02_arb_pick.
module t02_mem_arbiter
    import t02_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    output logic              Ren,
    output logic              Wen,
    input  logic [DATA_W-1:0] ramload,
    input  logic              busy_o
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    arb_state_t              state;
    arb_state_t              state_next;
    grant_t                  winner;
    grant_t                  grant_q;
    grant_t                  last_grant;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    take;

    t02_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign take     = (state == IDLE) && en && (i_req || d_req);
    assign ramaddr  = addr_q;
    assign ramstore = wdata_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = ISSUE;
            ISSUE:   state_next = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = WAIT;
            WAIT:    if (!busy_o) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Ren     = 1'b0;
        Wen     = 1'b0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        case (state)
            ISSUE: begin
                Ren = ~we_q;
                Wen = we_q;
            end
            DONE: begin
                i_ready = (grant_q == GNT_I);
                d_ready = (grant_q == GNT_D);
            end
            default: ;
        endcase
    end

    // Request copies are taken once at grant; later changes on the ports are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            grant_q    <= GNT_I;
            last_grant <= GNT_D;
            settle_cnt <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (take) begin
                grant_q    <= winner;
                last_grant <= winner;
                if (winner == GNT_D) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    we_q    <= d_we;
                end else begin
                    addr_q  <= i_addr;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                end
            end

            if (state == ISSUE) begin
                settle_cnt <= '0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
            end

            // Stores complete without touching either read-data register.
            if ((state == WAIT) && !busy_o && !we_q) begin
                if (grant_q == GNT_I) begin
                    i_rdata <= ramload;
                end else begin
                    d_rdata <= ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Scoreboard bench for t02_mem_arbiter: directed stimulus pushes expected
// strobes and ready responses; two monitors pop and compare on DUT activity.
module tb_t02_mem_arbiter;
    import t02_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, i_req, d_req, d_we, busy_o;
    logic [31:0] i_addr, d_addr, d_wdata, ramload;
    logic        i_ready, d_ready, Ren, Wen;
    logic [31:0] i_rdata, d_rdata, ramaddr, ramstore;

    int cyc = 0;
    int checks = 0;
    int passed = 0;
    int strobes_seen = 0;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic        chk_data;
        logic [31:0] data;
        int          cycle;
    } strobe_t;

    typedef struct {
        grant_t      port;
        logic [31:0] rdata;
        int          cycle;
    } resp_t;

    strobe_t strobe_q[$];
    resp_t   resp_q[$];

    t02_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .Ren      (Ren),
        .Wen      (Wen),
        .ramload  (ramload),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents: two fixed words, everything else a fixed pattern of the address.
    always_comb begin
        case (ramaddr)
            32'h0000_0040: ramload = 32'h0000_0513;
            32'h0000_0104: ramload = 32'hCAFE_F00D;
            default:       ramload = ramaddr ^ 32'hA5A5_0000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_strobe(input logic ren, input logic wen, input logic [31:0] addr,
                              input logic chk, input logic [31:0] data, input int cycle);
        strobe_q.push_back('{ren, wen, addr, chk, data, cycle});
    endtask

    task automatic exp_resp(input grant_t port, input logic [31:0] rdata, input int cycle);
        resp_q.push_back('{port, rdata, cycle});
    endtask

    // Holds the request until its ready pulse, then drops it before the next edge.
    task automatic wait_ready(input grant_t port);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if ((port == GNT_I && i_ready) || (port == GNT_D && d_ready)) seen = 1'b1;
        end
        if (port == GNT_I) i_req = 1'b0;
        else d_req = 1'b0;
        check(port == GNT_I ? "i_ready_seen" : "d_ready_seen", 32'(seen), 32'd1);
    endtask

    always @(negedge clk) begin
        strobe_t e;
        if (Ren || Wen) begin
            strobes_seen++;
            if (strobe_q.size() == 0) begin
                check("unexpected_strobe", 32'd0, 32'd1);
            end else begin
                e = strobe_q.pop_front();
                check("strobe_ren", 32'(Ren), 32'(e.ren));
                check("strobe_wen", 32'(Wen), 32'(e.wen));
                check("strobe_addr", ramaddr, e.addr);
                check("strobe_cycle", cyc, e.cycle);
                if (e.chk_data) check("strobe_data", ramstore, e.data);
            end
        end
    end

    always @(negedge clk) begin
        resp_t r;
        if (i_ready && d_ready) check("both_ready", 32'd1, 32'd0);
        if (i_ready || d_ready) begin
            if (resp_q.size() == 0) begin
                check("unexpected_ready", 32'd0, 32'd1);
            end else begin
                r = resp_q.pop_front();
                check("ready_port", 32'(d_ready), 32'(r.port == GNT_D));
                check("ready_rdata", d_ready ? d_rdata : i_rdata, r.rdata);
                check("ready_cycle", cyc, r.cycle);
            end
        end
    end

    // Both requesters raised together; expected order depends on the tie policy.
    task automatic tie(input logic [31:0] ia, input logic [31:0] da);
        int n;
        i_addr = ia;
        d_addr = da;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        n = cyc;
`ifdef T02_ARB_ROUND_ROBIN_EN
        exp_strobe(1'b1, 1'b0, ia, 1'b0, 32'h0, n + 1);
        exp_resp(GNT_I, ia ^ 32'hA5A5_0000, n + 4);
        exp_strobe(1'b1, 1'b0, da, 1'b0, 32'h0, n + 6);
        exp_resp(GNT_D, da ^ 32'hA5A5_0000, n + 9);
`else
        exp_strobe(1'b1, 1'b0, da, 1'b0, 32'h0, n + 1);
        exp_resp(GNT_D, da ^ 32'hA5A5_0000, n + 4);
        exp_strobe(1'b1, 1'b0, ia, 1'b0, 32'h0, n + 6);
        exp_resp(GNT_I, ia ^ 32'hA5A5_0000, n + 9);
`endif
        fork
            wait_ready(GNT_I);
            wait_ready(GNT_D);
        join
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        rst = 1'b1; en = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; busy_o = 1'b0;
        repeat (3) tick();
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_ren", 32'(Ren), 32'd0);
        check("rst_wen", 32'(Wen), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Reset landing on ISSUE aborts the fetch with no ready pulse.
        i_addr = 32'h80; i_req = 1'b1; n = cyc;
        exp_strobe(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, n + 1);
        tick();
        rst = 1'b1;
        tick();
        i_req = 1'b0;
        check("abort_ren", 32'(Ren), 32'd0);
        check("abort_ramaddr", ramaddr, 32'd0);
        check("abort_i_rdata", i_rdata, 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Single fetch, no busy.
        i_addr = 32'h40; i_req = 1'b1; n = cyc;
        exp_strobe(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, n + 1);
        exp_resp(GNT_I, 32'h0000_0513, n + 4);
        wait_ready(GNT_I);
        check("fetch_ramaddr_hold", ramaddr, 32'h40);
        tick(); tick();
        check("fetch_rdata_stable", i_rdata, 32'h0000_0513);

        // Store with busy high for three cycles starting at N+2.
        d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1; n = cyc;
        exp_strobe(1'b0, 1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF, n + 1);
        exp_resp(GNT_D, 32'h0, n + 6);
        fork
            begin
                tick(); tick();
                busy_o = 1'b1;
                tick(); tick(); tick();
                busy_o = 1'b0;
            end
            wait_ready(GNT_D);
        join
        check("store_ramstore_hold", ramstore, 32'hDEAD_BEEF);
        d_we = 1'b0;
        tick();

        // Load, then a store that must leave d_rdata alone.
        d_addr = 32'h104; d_req = 1'b1; n = cyc;
        exp_strobe(1'b1, 1'b0, 32'h104, 1'b0, 32'h0, n + 1);
        exp_resp(GNT_D, 32'hCAFE_F00D, n + 4);
        wait_ready(GNT_D);
        tick();
        d_addr = 32'h108; d_wdata = 32'h0BAD_F00D; d_we = 1'b1; d_req = 1'b1; n = cyc;
        exp_strobe(1'b0, 1'b1, 32'h108, 1'b1, 32'h0BAD_F00D, n + 1);
        exp_resp(GNT_D, 32'hCAFE_F00D, n + 4);
        wait_ready(GNT_D);
        d_we = 1'b0;
        tick();

        tie(32'h200, 32'h300);
        tie(32'h210, 32'h310);

        // Address changes and request drops after grant are ignored.
        i_addr = 32'h500; i_req = 1'b1; n = cyc;
        exp_strobe(1'b1, 1'b0, 32'h500, 1'b0, 32'h0, n + 1);
        exp_resp(GNT_I, 32'hA5A5_0500, n + 4);
        tick();
        i_addr = 32'h600;
        tick();
        i_req = 1'b0;
        wait_ready(GNT_I);
        tick();

        // en low blocks grants; en dropping during WAIT does not.
        en = 1'b0; i_addr = 32'h400; i_req = 1'b1; s0 = strobes_seen;
        repeat (10) tick();
        check("en_low_no_strobe", 32'(strobes_seen - s0), 32'd0);
        en = 1'b1; n = cyc;
        exp_strobe(1'b1, 1'b0, 32'h400, 1'b0, 32'h0, n + 1);
        exp_resp(GNT_I, 32'hA5A5_0400, n + 4);
        fork
            begin
                tick(); tick(); tick();
                en = 1'b0;
            end
            wait_ready(GNT_I);
        join
        en = 1'b1;

        repeat (3) tick();
        check("strobe_q_empty", 32'(strobe_q.size()), 32'd0);
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
